// File: rtl/sw_pe_array_core.sv
// Smith-Waterman systolic core: query loading, valid/ready target streaming through a
// linear PE chain, pipeline drain, then a sequential scan for the best local score.
module sw_pe_array_core #(
  parameter int LEN    = 64,
  parameter int CHAR_W = 2,
  parameter int W      = 12,
  parameter int IDX_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [W-1:0]           cfg_match,
  input  logic [W-1:0]           cfg_mismatch,
  input  logic [W-1:0]           cfg_alpha,
  input  logic [W-1:0]           cfg_beta,
  input  logic                   q_valid,
  input  logic [CHAR_W-1:0]      q_char,
  input  logic                   q_last,
  output logic                   q_ready,
  input  logic                   t_valid,
  input  logic [CHAR_W-1:0]      t_char,
  input  logic                   t_last,
  output logic                   t_ready,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           max_score,
  output logic [$clog2(LEN)-1:0] max_i,
  output logic [IDX_W-1:0]       max_j
);
  localparam int IW = $clog2(LEN);
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_Q, S_RUN, S_DRAIN, S_SCAN, S_DONE} state_t;

  state_t            state_reg;
  logic [W-1:0]      match_reg, mismatch_reg, alpha_reg, beta_reg;
  logic [CW-1:0]     qcnt_reg, qlen_reg, cnt_reg;
  logic [IDX_W-1:0]  j_reg, inj_j_reg;
  logic [CHAR_W-1:0] inj_c_reg;
  logic              inj_v_reg;
  logic              q_ready_reg, t_ready_reg, busy_reg, done_reg;
  logic [W-1:0]      max_score_reg;
  logic [IW-1:0]     max_i_reg;
  logic [IDX_W-1:0]  max_j_reg;

  // Per-PE state; pc/pv/pj carry the target char, its valid bit and j down the chain.
  logic [CHAR_W-1:0] q_arr [LEN];
  logic [CHAR_W-1:0] pc_arr [LEN];
  logic              pv_arr [LEN];
  logic [IDX_W-1:0]  pj_arr [LEN];
  logic [W-1:0]      h_arr [LEN];
  logic [W-1:0]      e_arr [LEN];
  logic [W-1:0]      f_arr [LEN];
  logic [W-1:0]      diag_arr [LEN];
  logic [W-1:0]      best_arr [LEN];
  logic [IDX_W-1:0]  best_j_arr [LEN];

  logic          q_we, clear_pe;
  logic [CW-1:0] q_idx;

  assign q_we     = q_valid && q_ready_reg;
  assign clear_pe = q_we && (state_reg == S_IDLE);
  assign q_idx    = (state_reg == S_IDLE) ? '0 : qcnt_reg;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? '1 : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  for (genvar gi = 0; gi < LEN; gi++) begin : g_pe
    logic [CHAR_W-1:0] in_c;
    logic              in_v;
    logic [IDX_W-1:0]  in_j;
    logic [W-1:0]      in_h, in_f, e_new, f_new, d_new, h_new;

    if (gi == 0) begin : g_head
      assign in_c = inj_c_reg;
      assign in_v = inj_v_reg;
      assign in_j = inj_j_reg;
      assign in_h = '0;
      assign in_f = '0;
    end else begin : g_link
      assign in_c = pc_arr[gi-1];
      assign in_v = pv_arr[gi-1];
      assign in_j = pj_arr[gi-1];
      assign in_h = h_arr[gi-1];
      assign in_f = f_arr[gi-1];
    end

    assign e_new = max2(sat_sub(h_arr[gi], alpha_reg), sat_sub(e_arr[gi], beta_reg));
    assign f_new = max2(sat_sub(in_h, alpha_reg), sat_sub(in_f, beta_reg));
    assign d_new = (q_arr[gi] == in_c) ? sat_add(diag_arr[gi], match_reg)
                                       : sat_sub(diag_arr[gi], mismatch_reg);
    assign h_new = max2(d_new, max2(e_new, f_new));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_arr[gi]      <= '0;
        pc_arr[gi]     <= '0;
        pv_arr[gi]     <= 1'b0;
        pj_arr[gi]     <= '0;
        h_arr[gi]      <= '0;
        e_arr[gi]      <= '0;
        f_arr[gi]      <= '0;
        diag_arr[gi]   <= '0;
        best_arr[gi]   <= '0;
        best_j_arr[gi] <= '0;
      end else begin
        if (q_we && q_idx == CW'(gi)) q_arr[gi] <= q_char;
        if (clear_pe) begin
          pv_arr[gi]     <= 1'b0;
          h_arr[gi]      <= '0;
          e_arr[gi]      <= '0;
          f_arr[gi]      <= '0;
          diag_arr[gi]   <= '0;
          best_arr[gi]   <= '0;
          best_j_arr[gi] <= '0;
        end else begin
          pv_arr[gi] <= in_v;
          pc_arr[gi] <= in_c;
          pj_arr[gi] <= in_j;
          // Bubbles leave the score state untouched so they never alter the result.
          if (in_v) begin
            e_arr[gi]    <= e_new;
            f_arr[gi]    <= f_new;
            h_arr[gi]    <= h_new;
            diag_arr[gi] <= in_h;
            if (h_new > best_arr[gi]) begin
              best_arr[gi]   <= h_new;
              best_j_arr[gi] <= in_j;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      match_reg     <= '0;
      mismatch_reg  <= '0;
      alpha_reg     <= '0;
      beta_reg      <= '0;
      qcnt_reg      <= '0;
      qlen_reg      <= '0;
      cnt_reg       <= '0;
      j_reg         <= '0;
      inj_c_reg     <= '0;
      inj_v_reg     <= 1'b0;
      inj_j_reg     <= '0;
      q_ready_reg   <= 1'b1;
      t_ready_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      max_score_reg <= '0;
      max_i_reg     <= '0;
      max_j_reg     <= '0;
    end else begin
      done_reg  <= 1'b0;
      inj_v_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cfg_we) begin
            match_reg    <= cfg_match;
            mismatch_reg <= cfg_mismatch;
            alpha_reg    <= cfg_alpha;
            beta_reg     <= cfg_beta;
          end
          if (q_valid) begin
            j_reg         <= '0;
            max_score_reg <= '0;
            max_i_reg     <= '0;
            max_j_reg     <= '0;
            busy_reg      <= 1'b1;
            if (q_last || LEN == 1) begin
              qlen_reg    <= CW'(1);
              q_ready_reg <= 1'b0;
              t_ready_reg <= 1'b1;
              state_reg   <= S_RUN;
            end else begin
              qcnt_reg  <= CW'(1);
              state_reg <= S_LOAD_Q;
            end
          end
        end
        S_LOAD_Q: begin
          if (q_valid) begin
            if (q_last || qcnt_reg == CW'(LEN - 1)) begin
              qlen_reg    <= qcnt_reg + CW'(1);
              q_ready_reg <= 1'b0;
              t_ready_reg <= 1'b1;
              state_reg   <= S_RUN;
            end else begin
              qcnt_reg <= qcnt_reg + CW'(1);
            end
          end
        end
        S_RUN: begin
          if (t_valid) begin
            inj_v_reg <= 1'b1;
            inj_c_reg <= t_char;
            inj_j_reg <= j_reg;
            j_reg     <= j_reg + IDX_W'(1);
            if (t_last) begin
              t_ready_reg <= 1'b0;
              cnt_reg     <= '0;
              state_reg   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == qlen_reg - CW'(1)) begin
            cnt_reg   <= '0;
            state_reg <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (best_arr[cnt_reg[IW-1:0]] > max_score_reg) begin
            max_score_reg <= best_arr[cnt_reg[IW-1:0]];
            max_i_reg     <= cnt_reg[IW-1:0];
            max_j_reg     <= best_j_arr[cnt_reg[IW-1:0]];
          end
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == qlen_reg - CW'(1)) begin
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          q_ready_reg <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign q_ready   = q_ready_reg;
  assign t_ready   = t_ready_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign max_score = max_score_reg;
  assign max_i     = max_i_reg;
  assign max_j     = max_j_reg;
endmodule

// File: tb/tb_sw_pe_array_core.sv
// Bench for sw_pe_array_core: directed cases plus random jobs scored against a
// full dynamic-programming matrix model of local alignment.
module tb_sw_pe_array_core;
  localparam int LEN    = 8;
  localparam int CHAR_W = 2;
  localparam int W      = 4;
  localparam int IDX_W  = 16;
  localparam int TMAX   = 24;
  localparam int MAXV   = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  logic [W-1:0] cfg_match, cfg_mismatch, cfg_alpha, cfg_beta;
  logic q_valid, q_last, q_ready;
  logic [CHAR_W-1:0] q_char;
  logic t_valid, t_last, t_ready;
  logic [CHAR_W-1:0] t_char;
  logic busy, done;
  logic [W-1:0] max_score;
  logic [$clog2(LEN)-1:0] max_i;
  logic [IDX_W-1:0] max_j;

  int checks = 0;
  int errors = 0;
  logic [CHAR_W-1:0] qs [LEN];
  logic [CHAR_W-1:0] ts [TMAX];
  int cm, cmm, ca, cb;

  sw_pe_array_core #(.LEN(LEN), .CHAR_W(CHAR_W), .W(W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we),
    .cfg_match(cfg_match), .cfg_mismatch(cfg_mismatch),
    .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta),
    .q_valid(q_valid), .q_char(q_char), .q_last(q_last), .q_ready(q_ready),
    .t_valid(t_valid), .t_char(t_char), .t_last(t_last), .t_ready(t_ready),
    .busy(busy), .done(done), .max_score(max_score), .max_i(max_i), .max_j(max_j)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ssub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction
  function automatic int sadd(input int a, input int b);
    return (a + b > MAXV) ? MAXV : a + b;
  endfunction
  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Full H/E/F matrices; the first cell in row-major order holding the maximum wins.
  task automatic ref_model(input int ql, input int tl, output int bs, output int bi, output int bj);
    int hm [LEN][TMAX];
    int em [LEN][TMAX];
    int fm [LEN][TMAX];
    bs = 0; bi = 0; bj = 0;
    for (int i = 0; i < ql; i++) begin
      for (int j = 0; j < tl; j++) begin
        int hl, el, hu, fu, hd, d;
        hl = (j > 0) ? hm[i][j-1] : 0;
        el = (j > 0) ? em[i][j-1] : 0;
        hu = (i > 0) ? hm[i-1][j] : 0;
        fu = (i > 0) ? fm[i-1][j] : 0;
        hd = (i > 0 && j > 0) ? hm[i-1][j-1] : 0;
        em[i][j] = mx(ssub(hl, ca), ssub(el, cb));
        fm[i][j] = mx(ssub(hu, ca), ssub(fu, cb));
        d = (qs[i] == ts[j]) ? sadd(hd, cm) : ssub(hd, cmm);
        hm[i][j] = mx(mx(0, d), mx(em[i][j], fm[i][j]));
        if (hm[i][j] > bs) begin
          bs = hm[i][j]; bi = i; bj = j;
        end
      end
    end
  endtask

  task automatic set_cfg(input int m, input int mm, input int a, input int b);
    cm = m; cmm = mm; ca = a; cb = b;
    cfg_we = 1'b1;
    cfg_match = W'(m); cfg_mismatch = W'(mm); cfg_alpha = W'(a); cfg_beta = W'(b);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_query(input int ql, input bit nolast);
    for (int k = 0; k < ql; k++) begin
      q_valid = 1'b1;
      q_char  = qs[k];
      q_last  = (k == ql - 1) && !(ql == LEN && nolast);
      @(posedge clk); #1;
    end
    q_valid = 1'b0;
    q_last  = 1'b0;
  endtask

  // bub: 0 none, 1 alternate idle cycles, 2 random idle cycles
  task automatic stream_target(input int tl, input int bub, input bit midcfg, input bit send_last);
    int k = 0;
    int guard = 0;
    bit hs;
    while (k < tl && guard < 10 * TMAX + 20) begin
      if ((bub == 1 && guard % 2 == 1) || (bub == 2 && $urandom_range(0, 1) == 0)) begin
        t_valid = 1'b0;
      end else begin
        t_valid = 1'b1;
        t_char  = ts[k];
        t_last  = (k == tl - 1) && send_last;
      end
      if (midcfg) begin
        cfg_we = 1'b1;
        cfg_match = W'($urandom); cfg_mismatch = W'($urandom);
        cfg_alpha = W'($urandom); cfg_beta = W'($urandom);
      end
      hs = t_valid && t_ready;
      @(posedge clk); #1;
      if (hs) k++;
      guard++;
    end
    if (k < tl) chk("t_timeout", k, tl);
    t_valid = 1'b0;
    t_last  = 1'b0;
    cfg_we  = 1'b0;
  endtask

  task automatic run_job(input string tag, input int ql, input int tl, input int bub,
                         input bit midcfg, input bit nolast, input bit use_exp,
                         input int es, input int ei, input int ej);
    int n = 1;
    int bs, bi, bj;
    if (use_exp) begin
      bs = es; bi = ei; bj = ej;
    end else begin
      ref_model(ql, tl, bs, bi, bj);
    end
    load_query(ql, nolast);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_t_ready"}, int'(t_ready), 1);
    chk({tag, "_q_ready"}, int'(q_ready), 0);
    stream_target(tl, bub, midcfg, 1'b1);
    while (!done && n < 4 * LEN + 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 2 * ql + 1);
    chk({tag, "_score"}, int'(max_score), bs);
    chk({tag, "_max_i"}, int'(max_i), bi);
    chk({tag, "_max_j"}, int'(max_j), bj);
    $display("job %s qlen %0d tlen %0d score %0d i %0d j %0d latency %0d",
             tag, ql, tl, max_score, max_i, max_j, n);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_hold_score"}, int'(max_score), bs);
  endtask

  task automatic set_acgt();
    for (int k = 0; k < 4; k++) begin
      qs[k] = CHAR_W'(k);
      ts[k] = CHAR_W'(k);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q_ready"}, int'(q_ready), 1);
    chk({tag, "_t_ready"}, int'(t_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_score"}, int'(max_score), 0);
    chk({tag, "_max_i"}, int'(max_i), 0);
    chk({tag, "_max_j"}, int'(max_j), 0);
  endtask

  initial begin
    int ql, tl;
    rst_n = 1'b0; cfg_we = 1'b0;
    cfg_match = '0; cfg_mismatch = '0; cfg_alpha = '0; cfg_beta = '0;
    q_valid = 1'b0; q_char = '0; q_last = 1'b0;
    t_valid = 1'b0; t_char = '0; t_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_cfg(2, 1, 2, 1);
    set_acgt();
    run_job("exact", 4, 4, 0, 1'b0, 1'b0, 1'b1, 8, 3, 3);

    ts[2] = 2'd3;
    run_job("tie_gap", 4, 3, 0, 1'b0, 1'b0, 1'b1, 4, 1, 1);

    for (int k = 0; k < 4; k++) begin qs[k] = 2'd0; ts[k] = 2'd1; end
    run_job("mismatch", 4, 4, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin qs[k] = 2'd0; ts[k] = 2'd0; end
    run_job("saturate", 8, 8, 0, 1'b0, 1'b0, 1'b1, 15, 7, 7);

    set_acgt();
    run_job("bubbles", 4, 4, 1, 1'b1, 1'b0, 1'b1, 8, 3, 3);

    qs[0] = 2'd2; ts[0] = 2'd1; ts[1] = 2'd2; ts[2] = 2'd2;
    run_job("qlen1", 1, 3, 0, 1'b0, 1'b0, 1'b1, 2, 0, 1);

    set_acgt();
    load_query(4, 1'b0);
    stream_target(2, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("postrst");
    cm = 0; cmm = 0; ca = 0; cb = 0;
    run_job("zero_cfg", 4, 4, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    set_cfg(2, 1, 2, 1);
    run_job("rerun", 4, 4, 0, 1'b0, 1'b0, 1'b1, 8, 3, 3);

    for (int r = 0; r < 20; r++) begin
      set_cfg($urandom_range(1, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      ql = $urandom_range(1, LEN);
      tl = $urandom_range(1, TMAX);
      for (int k = 0; k < LEN; k++) qs[k] = CHAR_W'($urandom);
      for (int k = 0; k < TMAX; k++) ts[k] = CHAR_W'($urandom);
      run_job("random", ql, tl, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sw_pe_array_core.md
# sw_pe_array_core

Parametrised Smith-Waterman systolic core. It generalises the fixed-length PE array with configurable array length, alphabet width and score width. It adds an on-chip control FSM for query loading, target streaming with valid/ready backpressure, pipeline drain, and a sequential best-score scan. It sits between the sequence loader and the result/traceback stage, and owns its scoring registers.

## Interface
- LEN, 64: number of PEs, which is also the maximum query length.
- CHAR_W, 2: bits per residue code.
- W, 12: score width; all V/E/F/H values are unsigned W-bit.
- IDX_W, 16: width of the target position counter and `max_j`.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  latches the four score fields; honoured only in IDLE.
- cfg_match / cfg_mismatch / cfg_alpha / cfg_beta  in  W each  match bonus; mismatch, gap-open and gap-extend penalty magnitudes.
- q_valid  in  1, q_char  in  CHAR_W, q_last  in  1  query stream.
- q_ready  out  1  high in IDLE and LOAD_Q.
- t_valid  in  1, t_char  in  CHAR_W, t_last  in  1  target stream.
- t_ready  out  1  high only in RUN.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is valid.
- max_score  out  W  best local score.
- max_i  out  $clog2(LEN)  0-based query index of the best cell.
- max_j  out  IDX_W  0-based target index of the best cell.

## Operation
- States: IDLE → LOAD_Q → RUN → DRAIN → SCAN → DONE → IDLE.
- IDLE:
  - A q_valid handshake writes q_char into PE0 and goes to LOAD_Q.
  - It also clears all PE E/H/local-best state, j, and the max outputs.
- LOAD_Q:
  - Each handshake writes q_char into PE[qcnt].
  - q_last, or the LEN-th char, sets qlen = qcnt+1 and goes to RUN.
  - A length-1 query (q_last on the first char) goes IDLE→RUN directly.
- RUN:
  - Each t_valid&t_ready injects {t_char, valid=1} into PE0, tagged with j, and increments j.
  - A cycle with no handshake injects a bubble (valid=0).
  - PEs whose incoming valid=0 hold all state.
  - t_last accepted → DRAIN.
- Per-PE recurrence for query index i and target index j. All subtractions saturate at 0; all additions saturate at 2^W−1.
  - E(i,j) = max(H(i,j−1)−alpha, E(i,j−1)−beta), held locally in the PE.
  - F(i,j) = max(H(i−1,j)−alpha, F(i−1,j)−beta), taken from the left neighbour.
  - H(i,j) = max(0, E, F, H(i−1,j−1) + (q_i==t_j ? match : −mismatch)).
  - Boundaries: PE0 sees H(−1,·)=F(−1,·)=0; each PE starts with H(i,−1)=E(i,−1)=0.
- Local best: each PE keeps (best H, j) and updates only on strictly greater H, so the earliest j wins a tie.
- PEs with i ≥ qlen compute but are excluded from SCAN.
- DRAIN: runs qlen cycles with bubbles injected, then goes to SCAN.
- SCAN:
  - Takes one PE per cycle for i = 0..qlen−1.
  - Updates the global max on strictly greater score, so the smallest i wins a tie.
  - After qlen cycles → DONE.
- DONE: done=1 for one cycle, then IDLE.
- max_* outputs: hold their value until the next job's first q handshake.
- cfg_we outside IDLE, q_valid outside IDLE/LOAD_Q, and t_valid outside RUN are ignored.

## Timing
- Reset values: state IDLE; q_ready=1; t_ready=0; busy=0; done=0; max_score/max_i/max_j=0; score registers=0; all PE registers=0.
- A reset assertion mid-job aborts immediately to these values; no partial result is reported.
- A target char accepted at cycle c is processed by PE k at cycle c+k+1, registered.
- Latency:
  - From the t_last handshake at cycle c, SCAN starts at c+qlen+1 and done is high at c+2·qlen+1.
  - For qlen=1: done at c+3.
- Throughput: one target char per cycle; bubbles cost one cycle each and do not change the result.
- j wraps at 2^IDX_W. Targets longer than that are unsupported and the wrapped index is reported.
- Score registers are stable from IDLE through DONE. A new cfg_we is legal again only in the cycle after done.

## Test plan
- Exact match:
  - Setup: cfg 2/1/2/1, query ACGT (0,1,2,3), target ACGT, no bubbles.
  - Expected: max_score=8, max_i=3, max_j=3; done exactly 2·4+1 cycles after t_last.
- Tie-break with a gap:
  - Setup: cfg 2/1/2/1, query ACGT, target ACT.
  - Expected: H=4 at both (1,1) and (3,2); max_score=4, max_i=1, max_j=1.
- All mismatch:
  - Setup: query AAAA, target CCCC.
  - Expected: max_score=0, max_i=0, max_j=0; done still pulses.
- Saturation:
  - Setup: W=4, LEN=8, match=2, query and target each 8×A.
  - Expected: max_score=15, max_i=7, max_j=7 (first cell reaching 15 is (7,7): H=16 clamped), no wrap.
- Backpressure and bubbles:
  - Setup: repeat the exact-match case with t_valid low on alternate cycles, and cfg_we pulsed during RUN with different values.
  - Expected: identical result; the mid-run cfg is ignored.
- Reset mid-operation:
  - Setup: assert rst_n=0 during RUN after 2 target chars.
  - Expected: all outputs at reset values. Then rerun the exact-match case and expect score 8 at (3,3).
